// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Field-level RV64 instruction encoder feeding a 2-entry output FIFO.
// Revision : 1.0
// ============================================================================
module instr_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter bit CHECK_IMM  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_f3,
  input  logic [6:0]  in_f7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err
);

  localparam logic [1:0] c_FULL    = 2'(FIFO_DEPTH);
  localparam logic [2:0] c_FMT_R   = 3'd0;
  localparam logic [2:0] c_FMT_I   = 3'd1;
  localparam logic [2:0] c_FMT_S   = 3'd2;
  localparam logic [2:0] c_FMT_B   = 3'd3;
  localparam logic [2:0] c_FMT_U   = 3'd4;
  localparam logic [2:0] c_FMT_J   = 3'd5;
  localparam logic [2:0] c_FMT_ISH = 3'd6;

  logic [31:0] w_instr;
  logic        w_imm_ok;
  logic        w_rsv;
  logic        w_err;
  logic        w_push;
  logic        w_pop;

  logic [1:0]  r_count;
  logic        r_wptr;
  logic        r_rptr;
  logic [31:0] r_mem_instr [2];
  logic        r_mem_err   [2];

  // Fields are truncated into place even when the range check fails.
  always_comb begin
    w_instr  = '0;
    w_imm_ok = 1'b1;
    w_rsv    = 1'b0;
    case (in_fmt)
      c_FMT_R: begin
        w_instr = {in_f7, in_rs2, in_rs1, in_f3, in_rd, in_opcode};
      end
      c_FMT_I: begin
        w_instr  = {in_imm[11:0], in_rs1, in_f3, in_rd, in_opcode};
        w_imm_ok = (in_imm == {{52{in_imm[11]}}, in_imm[11:0]});
      end
      c_FMT_S: begin
        w_instr  = {in_imm[11:5], in_rs2, in_rs1, in_f3, in_imm[4:0], in_opcode};
        w_imm_ok = (in_imm == {{52{in_imm[11]}}, in_imm[11:0]});
      end
      c_FMT_B: begin
        w_instr  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_f3,
                    in_imm[4:1], in_imm[11], in_opcode};
        w_imm_ok = (in_imm == {{51{in_imm[12]}}, in_imm[12:0]}) && !in_imm[0];
      end
      c_FMT_U: begin
        w_instr  = {in_imm[31:12], in_rd, in_opcode};
        w_imm_ok = (in_imm[11:0] == 12'd0) &&
                   (in_imm == {{32{in_imm[31]}}, in_imm[31:0]});
      end
      c_FMT_J: begin
        w_instr  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                    in_rd, in_opcode};
        w_imm_ok = (in_imm == {{43{in_imm[20]}}, in_imm[20:0]}) && !in_imm[0];
      end
      c_FMT_ISH: begin
        w_instr  = {in_f7[6:1], in_imm[5:0], in_rs1, in_f3, in_rd, in_opcode};
        w_imm_ok = (in_imm[63:6] == 58'd0);
      end
      default: begin
        w_rsv = 1'b1;
      end
    endcase
  end

  // Reserved format is always flagged, independent of immediate checking.
  assign w_err = w_rsv | (CHECK_IMM & ~w_imm_ok);

  assign in_ready  = (r_count != c_FULL);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count        <= 2'd0;
      r_wptr         <= 1'b0;
      r_rptr         <= 1'b0;
      r_mem_instr[0] <= '0;
      r_mem_instr[1] <= '0;
      r_mem_err[0]   <= 1'b0;
      r_mem_err[1]   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_instr[r_wptr] <= w_instr;
        r_mem_err[r_wptr]   <= w_err;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  assign out_instr = out_valid ? r_mem_instr[r_rptr] : 32'd0;
  assign out_err   = out_valid & r_mem_err[r_rptr];

endmodule
`default_nettype wire
